pipe_add: RTL
=============

// Module: pipe_add
// PURPOSE
//  Parametrised, pipelined carry-propagate adder. Successor to the single-cycle WIDETH full adder.
//  Operands are split into SEG_W-bit segments; one segment is added per pipeline stage, and the
//  carry ripples stage to stage through registers.
//  Valid/ready handshake on both sides; full throughput (1 op/clk); stalls on backpressure.
//  Sits between the operand-fetch logic and the result writeback in the datapath.
// PARAMETERS
//  WIDETH  32  operand/sum width in bits; must be a multiple of SEG_W
//  SEG_W   8   bits added per stage; NUM_SEG = WIDETH/SEG_W = latency in cycles (>=1)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst_n      in   1       synchronous active-low reset
//  in_valid   in   1       a/b/cin valid this cycle
//  in_ready   out  1       block accepts operands this cycle
//  a          in   WIDETH  operand A
//  b          in   WIDETH  operand B
//  cin        in   1       carry in to LSB segment
//  out_valid  out  1       sum/cout valid
//  out_ready  in   1       downstream accepts result
//  sum        out  WIDETH  (a+b+cin) mod 2^WIDETH
//  cout       out  1       carry out of MSB
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): all stage valid bits, out_valid, sum, cout (and ovf) -> 0.
//    Data registers also cleared. Reset mid-operation discards every in-flight op.
//  - advance = !out_valid || out_ready; in_ready = advance (combinational; 1 the cycle after reset).
//  - On advance, every stage shifts one step; stage0 captures a/b/cin and sets v0 = in_valid.
//    Bubbles (valid=0) are carried through the pipe like real ops.
//  - When !advance, all stages hold; sum/cout stable while out_valid && !out_ready.
//  - Stage k (0..NUM_SEG-1):
//    - adds a[k*SEG_W+:SEG_W] + b[k*SEG_W+:SEG_W] + carry_k, where carry_0 = cin and carry_k is
//      the registered carry of stage k-1;
//    - registers the SEG_W-bit partial sum alongside the lower partial sums;
//    - forwards the unconsumed upper operand segments.
//  - Latency: an op accepted at edge t appears with out_valid=1 after edge t+NUM_SEG-1 when not
//    stalled (NUM_SEG registered stages; output = last stage register).
//  - Each stage adder is SEG_W+1 bits wide; no arithmetic wider than that.
//    cout = carry out of the last stage.
//  - Wrap-around: all-ones + 1 gives sum=0, cout=1. cin=1 with a=b=all-ones gives sum=all-ones, cout=1.
//  - Simultaneous in_valid and out_ready while full: the output is consumed and the input
//    accepted in the same cycle; no bubble is inserted.
//  - NUM_SEG==1 degenerates to a registered single-cycle adder with identical handshake.
// CONFIGURATION
//  PIPE_ADD_OVF_EN defined:
//    - adds output port ovf (1 bit): signed two's-complement overflow =
//      carry into MSB XOR carry out of MSB;
//    - ovf is registered with sum, reset 0, and valid with out_valid.
//  PIPE_ADD_OVF_EN undefined: no ovf port and no ovf logic.
// STRUCTURE
//  - Shared package add_pkg:
//    - NUM_SEG calculation function;
//    - elaboration check (WIDETH % SEG_W == 0, SEG_W >= 1).
//  - Sub-module pipe_add_stage (param SEG_W):
//    - one segment adder, its registered carry, and its valid bit with hold-on-stall;
//    - instantiated NUM_SEG times in a generate loop.
//    Top level holds the skew registers for operand/partial-sum segments and the handshake.
// TESTING  (WIDETH=8, SEG_W=4 -> latency 2 unless noted)
//  1. a=8'hFF, b=8'h01, cin=0, out_ready=1 -> 2 edges later out_valid=1, sum=8'h00, cout=1.
//  2. Back-to-back: 16 random ops, one per cycle, out_ready=1 -> 16 consecutive out_valid
//     cycles, each matching the reference model a+b+cin; in_ready never drops.
//  3. Backpressure: out_ready=0, push ops 3+4, 5+6, 7+8 ->
//     - in_ready drops once 2 ops are held; out_valid=1, sum=8'h07 stable;
//     - raise out_ready -> 07, 0B, 0F in order; nothing lost or duplicated.
//  4. Reset mid-op: 2 ops in flight, rst_n=0 for 1 cycle -> out_valid=0, sum=0, cout=0 after the
//     edge; no stale result emerges afterwards.
//  5. Bubble: valid op, idle cycle, valid op -> out_valid pattern 1,0,1 with correct sums.
//  6. PIPE_ADD_OVF_EN: 8'h7F+8'h01 -> sum=8'h80, ovf=1, cout=0; 8'hFF+8'h01 -> ovf=0, cout=1.
//     WIDETH=32, SEG_W=8: 2^32-1 + 1 -> sum=0, cout=1 after 4 cycles.

Source files
------------

// File: rtl/add_pkg.sv
// add_pkg: sizing and configuration helpers shared by the pipe_add slice.
package add_pkg;

  function automatic int num_seg(input int w, input int s);
    return (s >= 1) ? w / s : 1;
  endfunction

  function automatic bit cfg_ok(input int w, input int s);
    return (s >= 1) && (w >= s) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// pipe_add_stage: one SEG_W-bit segment adder with registered sum,
// carry and valid; everything holds while adv is low.
module pipe_add_stage #(
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_v,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic             v,
  output logic [SEG_W-1:0] s,
  output logic             co
);

  logic [SEG_W:0] tot;

  assign tot = {1'b0, a} + {1'b0, b}
             + {{SEG_W{1'b0}}, ci};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v  <= 1'b0;
      s  <= '0;
      co <= 1'b0;
    end else if (adv) begin
      v  <= in_v;
      s  <= tot[SEG_W-1:0];
      co <= tot[SEG_W];
    end
  end

endmodule

// File: rtl/pipe_add.sv
// pipe_add: pipelined carry-propagate adder, one SEG_W segment per stage.
// Define PIPE_ADD_OVF_EN to add the registered signed-overflow output ovf.
module pipe_add
  import add_pkg::*;
#(
  parameter int WIDETH = 32,
  parameter int SEG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDETH-1:0] a,
  input  logic [WIDETH-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDETH-1:0] sum,
  output logic              cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int NSEG = num_seg(WIDETH, SEG_W);

  if (!cfg_ok(WIDETH, SEG_W)) begin : g_cfg_err
    $error("pipe_add: WIDETH must be a positive multiple of SEG_W");
  end

  logic            adv;
  logic [NSEG-1:0] v;
  logic [NSEG-1:0] c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Iteration k: operands still to be added (ain/bin, lowest segment
  // is the one stage k consumes) and the sums done so far (acc).
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int RW = WIDETH - k * SEG_W;
    localparam int LW = (k + 1) * SEG_W;

    logic [RW-1:0]    ain;
    logic [RW-1:0]    bin;
    logic [LW-1:0]    acc;
    logic [SEG_W-1:0] s;
    logic             vin;
    logic             cin_k;

    if (k == 0) begin : g_head
      assign ain   = a;
      assign bin   = b;
      assign vin   = in_valid;
      assign cin_k = cin;
      assign acc   = s;
    end else begin : g_body
      logic [RW-1:0]       aq;
      logic [RW-1:0]       bq;
      logic [LW-SEG_W-1:0] lq;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          aq <= '0;
          bq <= '0;
          lq <= '0;
        end else if (adv) begin
          aq <= g_seg[k-1].ain[RW+SEG_W-1:SEG_W];
          bq <= g_seg[k-1].bin[RW+SEG_W-1:SEG_W];
          lq <= g_seg[k-1].acc;
        end
      end

      assign ain   = aq;
      assign bin   = bq;
      assign vin   = v[k-1];
      assign cin_k = c[k-1];
      assign acc   = {s, lq};
    end

    pipe_add_stage #(
      .SEG_W(SEG_W)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (adv),
      .in_v (vin),
      .a    (ain[SEG_W-1:0]),
      .b    (bin[SEG_W-1:0]),
      .ci   (cin_k),
      .v    (v[k]),
      .s    (s),
      .co   (c[k])
    );
  end

  assign out_valid = v[NSEG-1];
  assign cout      = c[NSEG-1];
  assign sum       = g_seg[NSEG-1].acc;

`ifdef PIPE_ADD_OVF_EN
  // Carry into the MSB is recovered as a^b^sum at that bit.
  logic msbx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msbx_q <= 1'b0;
    end else if (adv) begin
      msbx_q <= g_seg[NSEG-1].ain[SEG_W-1]
              ^ g_seg[NSEG-1].bin[SEG_W-1];
    end
  end

  assign ovf = msbx_q ^ sum[WIDETH-1] ^ cout;
`endif

endmodule
